iter_div_unit: RTL and testbench

//  Multi-cycle iterative integer divider for the EX stage; replaces the single-cycle DivCon.

---
 rtl/iter_div_unit_pkg.sv | 12 +
 rtl/iter_div_unit_div_step.sv | 22 ++
 rtl/iter_div_unit.sv | 148 ++++++++++++++
 tb/tb_iter_div_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/iter_div_unit_pkg.sv
// Shared types for the iterative divider: FSM state encoding.
package iter_div_unit_pkg;

  typedef enum logic [2:0] {
    DIV_ST_IDLE = 3'd0,
    DIV_ST_PREP = 3'd1,
    DIV_ST_CALC = 3'd2,
    DIV_ST_FIX  = 3'd3,
    DIV_ST_DONE = 3'd4
  } div_state_e;

endpackage

// File: rtl/iter_div_unit_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits, and shift the new quotient bit in.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic           take;

  assign shifted = {rem_in[WIDTH-1:0], quo_in[WIDTH-1]};
  // rem_in[WIDTH] set would mean the shifted value overflowed the window, so it always fits
  assign take    = rem_in[WIDTH] | (shifted >= {1'b0, divisor});
  assign rem_out = take ? (shifted - {1'b0, divisor}) : shifted;
  assign quo_out = {quo_in[WIDTH-2:0], take};

endmodule

// File: rtl/iter_div_unit.sv
// Multi-cycle signed/unsigned integer divider, K quotient bits per cycle,
// valid/ready on both sides with a tag carried alongside each op.
module iter_div_unit
  import iter_div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int K     = 1,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_unsigned,
  input  logic             use_mod,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e state_q, state_d;

  logic             op_uns, op_mod, sign_q, sign_r, special_q;
  logic [TAG_W-1:0] tag_q;
  logic [WIDTH-1:0] quo_q, div_q;
  logic [WIDTH:0]   rem_q;
  logic [CNT_W-1:0] count;

  logic             accept;
  logic             s1, s2, div_zero, ovf;
  logic [WIDTH-1:0] mag1, mag2, q_fin, r_fin;

  logic [WIDTH:0]   rem_ch [0:K];
  logic [WIDTH-1:0] quo_ch [0:K];

  assign in_ready  = (state_q == DIV_ST_IDLE) & ~flush;
  assign accept    = in_valid & in_ready;
  assign busy      = (state_q != DIV_ST_IDLE);
  assign out_valid = (state_q == DIV_ST_DONE);

  // In PREP, quo_q/div_q still hold the raw operands latched at accept.
  assign s1       = ~op_uns & quo_q[WIDTH-1];
  assign s2       = ~op_uns & div_q[WIDTH-1];
  assign mag1     = s1 ? -quo_q : quo_q;
  assign mag2     = s2 ? -div_q : div_q;
  assign div_zero = (div_q == '0);
  assign ovf      = ~op_uns & (quo_q == MIN_VAL) & (div_q == '1);

  assign q_fin = (~special_q & sign_q) ? -quo_q : quo_q;
  assign r_fin = (~special_q & sign_r) ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  assign rem_ch[0] = rem_q;
  assign quo_ch[0] = quo_q;

  for (genvar k = 0; k < K; k++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_ch[k]),
      .quo_in  (quo_ch[k]),
      .divisor (div_q),
      .rem_out (rem_ch[k+1]),
      .quo_out (quo_ch[k+1])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= DIV_ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_ST_IDLE: if (accept) state_d = DIV_ST_PREP;
      DIV_ST_PREP: state_d = (div_zero | ovf) ? DIV_ST_FIX : DIV_ST_CALC;
      DIV_ST_CALC: if (count == CNT_W'(WIDTH - K)) state_d = DIV_ST_FIX;
      DIV_ST_FIX:  state_d = DIV_ST_DONE;
      DIV_ST_DONE: if (out_ready) state_d = DIV_ST_IDLE;
      default:     state_d = DIV_ST_IDLE;
    endcase
    if (flush) state_d = DIV_ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_uns    <= 1'b0;
      op_mod    <= 1'b0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      special_q <= 1'b0;
      tag_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      rem_q     <= '0;
      count     <= '0;
      result    <= '0;
      out_tag   <= '0;
    end else begin
      case (state_q)
        DIV_ST_IDLE: begin
          if (accept) begin
            op_uns <= is_unsigned;
            op_mod <= use_mod;
            quo_q  <= src1;
            div_q  <= src2;
            tag_q  <= in_tag;
          end
        end
        DIV_ST_PREP: begin
          sign_q    <= s1 ^ s2;
          sign_r    <= s1;
          special_q <= div_zero | ovf;
          count     <= '0;
          // Special cases park their final q/r in the working registers.
          if (div_zero) begin
            quo_q <= '1;
            rem_q <= {1'b0, quo_q};
          end else if (ovf) begin
            rem_q <= '0;
          end else begin
            quo_q <= mag1;
            div_q <= mag2;
            rem_q <= '0;
          end
        end
        DIV_ST_CALC: begin
          quo_q <= quo_ch[K];
          rem_q <= rem_ch[K];
          count <= count + CNT_W'(K);
        end
        DIV_ST_FIX: begin
          result  <= op_mod ? r_fin : q_fin;
          out_tag <= tag_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_div_unit.sv
// Bench for iter_div_unit: K=1,2,4 instances share stimulus; results and
// latency are compared against a plain-arithmetic division model.
module tb_iter_div_unit;

  localparam int W  = 32;
  localparam int TW = 6;
  localparam logic [W-1:0] MINV = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, is_unsigned, use_mod, out_ready;
  logic [W-1:0]  src1, src2;
  logic [TW-1:0] in_tag;

  logic          in_ready  [3];
  logic          out_valid [3];
  logic          busy      [3];
  logic [W-1:0]  result    [3];
  logic [TW-1:0] out_tag   [3];

  int            n_vec = 0;
  int            n_err = 0;
  bit            exp_act = 1'b0;
  logic [W-1:0]  exp_res;
  logic [TW-1:0] exp_tag;
  int            exp_lat [3];
  int            since   [3];
  bit            seen    [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    iter_div_unit #(.WIDTH(W), .K(1 << g), .TAG_W(TW)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready[g]),
      .is_unsigned (is_unsigned),
      .use_mod     (use_mod),
      .src1        (src1),
      .src2        (src2),
      .in_tag      (in_tag),
      .out_valid   (out_valid[g]),
      .out_ready   (out_ready),
      .result      (result[g]),
      .out_tag     (out_tag[g]),
      .busy        (busy[g])
    );
  end

  always #5 clk = ~clk;

  function automatic bit is_special(input logic [W-1:0] a, input logic [W-1:0] b, input bit uns);
    return (b == 0) || (!uns && a == MINV && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input bit uns, input bit md);
    logic [W-1:0] q, r;
    if (b == 0) begin
      q = '1; r = a;
    end else if (!uns && a == MINV && b == 32'hFFFF_FFFF) begin
      q = MINV; r = '0;
    end else if (uns) begin
      q = a / b; r = a % b;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return md ? r : q;
  endfunction

  // Edges since accept, counting the accept edge as 1.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset || flush)              since[i] = 0;
      else if (in_valid && in_ready[i]) since[i] = 1;
      else if (since[i] > 0)           since[i] = since[i] + 1;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (out_valid[i]) begin
        n_vec++;
        if (!exp_act) begin
          n_err++;
          $display("FAIL spurious_valid k%0d: got result %h, want no output", i, result[i]);
        end else begin
          if (result[i] !== exp_res || out_tag[i] !== exp_tag) begin
            n_err++;
            $display("FAIL result k%0d: got %h tag %h, want %h tag %h",
                     i, result[i], out_tag[i], exp_res, exp_tag);
          end
          if (!seen[i] && since[i] != exp_lat[i]) begin
            n_err++;
            $display("FAIL latency k%0d: got %0d, want %0d", i, since[i], exp_lat[i]);
          end
          seen[i] = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, expv);
    end
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 300; c++) begin
      if (in_ready[0] && in_ready[1] && in_ready[2]) return;
      step();
    end
    chk("wait_idle_timeout", 0, 1);
  endtask

  task automatic wait_done();
    for (int c = 0; c < 300; c++) begin
      if (seen[0] && seen[1] && seen[2] && !busy[0] && !busy[1] && !busy[2]) return;
      step();
    end
    chk("wait_done_timeout", 0, 1);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit uns,
                       input bit md, input logic [TW-1:0] tag, input logic [W-1:0] expv);
    bit sp;
    wait_idle();
    sp      = is_special(a, b, uns);
    exp_res = expv;
    exp_tag = tag;
    exp_act = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_lat[i] = sp ? 3 : W / (1 << i) + 3;
      seen[i]    = 1'b0;
    end
    src1 = a; src2 = b; is_unsigned = uns; use_mod = md; in_tag = tag;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit uns,
                        input bit md, input logic [TW-1:0] tag, input logic [W-1:0] expv);
    issue(a, b, uns, md, tag, expv);
    wait_done();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    bit           uns, md;
    int           r;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; is_unsigned = 1'b0; use_mod = 1'b0;
    out_ready = 1'b1; src1 = '0; src2 = '0; in_tag = '0;
    for (int i = 0; i < 3; i++) begin since[i] = 0; seen[i] = 1'b0; end
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      chk("rst_out_valid", {31'd0, out_valid[i]}, 0);
      chk("rst_busy",      {31'd0, busy[i]}, 0);
      chk("rst_result",    result[i], 0);
      chk("rst_out_tag",   {26'd0, out_tag[i]}, 0);
      chk("rst_in_ready",  {31'd0, in_ready[i]}, 1);
    end
    reset = 1'b0;
    step();

    // Hand-computed literals pin the model.
    chk("model_udiv",   ref_div(32'hFFFF_FFFF, 2, 1, 0), 32'h7FFF_FFFF);
    chk("model_sdiv",   ref_div(-32'sd7, 2, 0, 0),       32'hFFFF_FFFD);
    chk("model_smod",   ref_div(-32'sd7, 2, 0, 1),       32'hFFFF_FFFF);
    chk("model_smod2",  ref_div(7, -32'sd2, 0, 1),       32'h1);
    chk("model_div0q",  ref_div(32'h1234, 0, 0, 0),      32'hFFFF_FFFF);
    chk("model_ovf",    ref_div(MINV, 32'hFFFF_FFFF, 0, 0), MINV);

    run_op(32'hFFFF_FFFF, 2, 1, 0, 6'h2A, 32'h7FFF_FFFF);
    run_op(-32'sd7, 2, 0, 0, 6'h01, 32'hFFFF_FFFD);
    run_op(-32'sd7, 2, 0, 1, 6'h02, 32'hFFFF_FFFF);
    run_op(7, -32'sd2, 0, 1, 6'h03, 32'h0000_0001);
    run_op(32'h1234, 0, 0, 0, 6'h04, 32'hFFFF_FFFF);
    run_op(32'h1234, 0, 1, 1, 6'h05, 32'h0000_1234);
    run_op(MINV, 32'hFFFF_FFFF, 0, 0, 6'h06, MINV);
    run_op(MINV, 32'hFFFF_FFFF, 0, 1, 6'h07, 32'h0);

    // Consumer stall in DONE.
    out_ready = 1'b0;
    issue(1000, 7, 1, 0, 6'h11, 32'd142);
    for (int c = 0; c < 300; c++) begin
      if (out_valid[0] && out_valid[1] && out_valid[2]) break;
      step();
    end
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < 3; i++) begin
        chk("stall_valid",    {31'd0, out_valid[i]}, 1);
        chk("stall_in_ready", {31'd0, in_ready[i]}, 0);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("release_busy",  {31'd0, busy[i]}, 0);
      chk("release_valid", {31'd0, out_valid[i]}, 0);
    end

    // Flush the K=1 unit at CALC count=10; the K=4 unit finishes before that.
    issue(1000, 3, 1, 0, 6'h15, 32'd333);
    for (int c = 0; c < 100; c++) begin
      if (since[0] == 12) break;
      step();
    end
    chk("flush_reach", since[0], 12);
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("flush_valid",    {31'd0, out_valid[i]}, 0);
      chk("flush_in_ready", {31'd0, in_ready[i]}, 1);
    end
    chk("flush_k1_silent", {31'd0, seen[0]}, 0);
    chk("flush_k2_silent", {31'd0, seen[1]}, 0);
    run_op(100, 7, 0, 0, 6'h22, 32'd14);

    for (int n = 0; n < 40; n++) begin
      a   = $urandom;
      r   = $urandom_range(0, 9);
      uns = $urandom_range(0, 1);
      md  = $urandom_range(0, 1);
      if (r == 0)      b = '0;
      else if (r == 1) begin b = 32'hFFFF_FFFF; a = MINV; end
      else if (r < 5)  b = $urandom_range(1, 20);
      else if (r == 5) b = -$urandom_range(1, 20);
      else             b = $urandom;
      run_op(a, b, uns, md, TW'($urandom), ref_div(a, b, uns, md));
    end

    exp_act = 1'b0;
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
